// File: rtl/vga_timing_core.sv
// VGA raster timing generator: free-running h/v counters, a pixel request port,
// and a PIX_LAT+1 stage pipeline that realigns syncs/strobes with the returned colour.
module vga_timing_core #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COLOR_W   = 4,
  parameter int PIX_LAT   = 1,
  parameter int CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  input  logic [3*COLOR_W-1:0] color_in,
  output logic [CNT_W-1:0]     next_x,
  output logic [CNT_W-1:0]     next_y,
  output logic                 next_valid,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic             w_active, w_hs_raw, w_vs_raw, w_ls_raw, w_fs_raw;
  logic [PIX_LAT:0] r_vld_sr, r_hs_sr, r_vs_sr, r_ls_sr, r_fs_sr;
  logic [3*COLOR_W-1:0] r_color;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pix_en) begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_raw = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign w_vs_raw = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign w_ls_raw = (r_h_cnt == '0);
  assign w_fs_raw = w_ls_raw && (r_v_cnt == '0);

  // Request port is masked during reset so the pixel source never sees a stale coordinate.
  assign next_valid = w_active && !rst;
  assign next_x     = next_valid ? r_h_cnt : '0;
  assign next_y     = next_valid ? r_v_cnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_sr <= '0;
      r_hs_sr  <= '0;
      r_vs_sr  <= '0;
      r_ls_sr  <= '0;
      r_fs_sr  <= '0;
      r_color  <= '0;
    end else if (pix_en) begin
      r_vld_sr <= {r_vld_sr[PIX_LAT-1:0], w_active};
      r_hs_sr  <= {r_hs_sr[PIX_LAT-1:0], w_hs_raw};
      r_vs_sr  <= {r_vs_sr[PIX_LAT-1:0], w_vs_raw};
      r_ls_sr  <= {r_ls_sr[PIX_LAT-1:0], w_ls_raw};
      r_fs_sr  <= {r_fs_sr[PIX_LAT-1:0], w_fs_raw};
      // color_in belongs to the request now sitting PIX_LAT stages deep.
      r_color  <= r_vld_sr[PIX_LAT-1] ? color_in : '0;
    end
  end

  assign de          = r_vld_sr[PIX_LAT];
  assign line_start  = r_ls_sr[PIX_LAT];
  assign frame_start = r_fs_sr[PIX_LAT];
  assign hsync       = r_hs_sr[PIX_LAT] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = r_vs_sr[PIX_LAT] ? VSYNC_POL : ~VSYNC_POL;
  assign red         = r_color[3*COLOR_W-1:2*COLOR_W];
  assign green       = r_color[2*COLOR_W-1:COLOR_W];
  assign blue        = r_color[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core on a reduced raster; expected outputs come from a
// pixel-index model (index -> h,v -> region flags) delayed by PIX_LAT+1 enabled cycles.
module tb_vga_timing_core;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 5, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit HPOL = 1'b1, VPOL = 1'b0;
  localparam int LAT = 3;
  localparam int CW = 4;
  localparam int NW = 8;

  logic clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
  logic [3*CW-1:0] color_in = '0;
  logic [NW-1:0] next_x, next_y;
  logic next_valid, hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] red, green, blue;

  int vectors = 0, miscompares = 0;
  int model_n = 0;

  vga_timing_core #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .COLOR_W(CW), .PIX_LAT(LAT), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .color_in(color_in),
    .next_x(next_x), .next_y(next_y), .next_valid(next_valid),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  wire [16:0] w_out = {hsync, vsync, de, line_start, frame_start, red, green, blue};
  wire [16:0] w_req = {next_valid, next_x, next_y};

  function automatic logic [11:0] pix_color(int h, int v);
    logic [3:0] hx, vy;
    hx = 4'(h);
    vy = 4'(v);
    return {hx, vy, hx ^ vy ^ 4'h5};
  endfunction

  // Output expected after n enabled edges since reset: reflects pixel index n-LAT-1.
  function automatic logic [16:0] exp_out(int n);
    int k, h, v;
    logic act, hs_a, vs_a, ls, fs;
    logic [11:0] c;
    k = n - LAT - 1;
    if (k < 0) return {~HPOL, ~VPOL, 3'b000, 12'h000};
    h = k % HT;
    v = (k / HT) % VT;
    act  = (h < HA) && (v < VA);
    hs_a = (h >= HA + HF) && (h < HA + HF + HS);
    vs_a = (v >= VA + VF) && (v < VA + VF + VS);
    ls   = (h == 0);
    fs   = ls && (v == 0);
    c    = act ? pix_color(h, v) : 12'h000;
    return {hs_a ? HPOL : ~HPOL, vs_a ? VPOL : ~VPOL, act, ls, fs, c};
  endfunction

  function automatic logic [16:0] exp_req(int n, logic r);
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    if (r || h >= HA || v >= VA) return 17'h0;
    return {1'b1, 8'(h), 8'(v)};
  endfunction

  // Drive one cycle; the pixel source answers requests LAT enabled cycles late, garbage otherwise.
  task automatic drive(input bit en, input bit r);
    int k, h, v;
    @(negedge clk);
    pix_en = en;
    rst = r;
    k = model_n - LAT;
    h = k % HT;
    v = (k / HT) % VT;
    if (!r && k >= 0 && h < HA && v < VA) color_in = pix_color(h, v);
    else color_in = 12'($urandom);
    @(posedge clk);
    if (r) model_n = 0;
    else if (en) model_n++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'b1);
      vectors++;
      if (w_out !== exp_out(0)) begin
        miscompares++;
        $display("FAIL reset_out cyc=%0d got %h exp %h", i, w_out, exp_out(0));
      end
      vectors++;
      if (w_req !== 17'h0) begin
        miscompares++;
        $display("FAIL reset_req cyc=%0d got %h exp 0", i, w_req);
      end
    end
    drive(1'b0, 1'b0);
    vectors++;
    if (w_req !== {1'b1, 8'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_first_req got %h exp %h", w_req, {1'b1, 8'd0, 8'd0});
    end
  endtask

  task automatic test_continuous();
    int hs_c = 0, vs_c = 0, de_c = 0, ls_c = 0, fs_c = 0, fs_alone = 0, max_x = 0;
    drive(1'b1, 1'b1);
    for (int i = 0; i < LAT + 2 * FRAME; i++) begin
      drive(1'b1, 1'b0);
      vectors++;
      if (w_out !== exp_out(model_n)) begin
        miscompares++;
        $display("FAIL cont_out n=%0d got %h exp %h", model_n, w_out, exp_out(model_n));
      end
      vectors++;
      if (w_req !== exp_req(model_n, 1'b0)) begin
        miscompares++;
        $display("FAIL cont_req n=%0d got %h exp %h", model_n, w_req, exp_req(model_n, 1'b0));
      end
      if (next_valid && int'(next_x) > max_x) max_x = int'(next_x);
      if (model_n >= LAT + 1) begin
        if (hsync == HPOL) hs_c++;
        if (vsync == VPOL) vs_c++;
        if (de) de_c++;
        if (line_start) ls_c++;
        if (frame_start) fs_c++;
        if (frame_start && !line_start) fs_alone++;
      end
    end
    vectors++;
    if (hs_c !== 2 * HS * VT) begin miscompares++; $display("FAIL hsync_count got %0d exp %0d", hs_c, 2 * HS * VT); end
    vectors++;
    if (vs_c !== 2 * VS * HT) begin miscompares++; $display("FAIL vsync_count got %0d exp %0d", vs_c, 2 * VS * HT); end
    vectors++;
    if (de_c !== 2 * HA * VA) begin miscompares++; $display("FAIL de_count got %0d exp %0d", de_c, 2 * HA * VA); end
    vectors++;
    if (ls_c !== 2 * VT) begin miscompares++; $display("FAIL line_start_count got %0d exp %0d", ls_c, 2 * VT); end
    vectors++;
    if (fs_c !== 2 || fs_alone !== 0) begin
      miscompares++;
      $display("FAIL frame_start_count got %0d alone %0d exp 2 alone 0", fs_c, fs_alone);
    end
    vectors++;
    if (max_x !== HA - 1) begin miscompares++; $display("FAIL max_next_x got %0d exp %0d", max_x, HA - 1); end
  endtask

  task automatic test_pix_en_random();
    drive(1'b1, 1'b1);
    for (int i = 0; i < 3 * FRAME + 40; i++) begin
      drive(($urandom % 3) == 0, 1'b0);
      vectors++;
      if (w_out !== exp_out(model_n)) begin
        miscompares++;
        $display("FAIL rand_out n=%0d got %h exp %h", model_n, w_out, exp_out(model_n));
      end
      vectors++;
      if (w_req !== exp_req(model_n, 1'b0)) begin
        miscompares++;
        $display("FAIL rand_req n=%0d got %h exp %h", model_n, w_req, exp_req(model_n, 1'b0));
      end
    end
  endtask

  task automatic test_midframe_reset();
    int budget = 0;
    // Land inside both the hsync and vsync windows, then abort.
    while (!((model_n % HT) == HA + HF + 1 && ((model_n / HT) % VT) == VA + VF) && budget < 4000) begin
      drive(($urandom % 2) == 0, 1'b0);
      budget++;
    end
    vectors++;
    if (budget >= 4000) begin
      miscompares++;
      $display("FAIL midframe_reach got budget %0d exp < 4000", budget);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'b1);
      vectors++;
      if (w_out !== exp_out(0)) begin
        miscompares++;
        $display("FAIL mid_reset_out cyc=%0d got %h exp %h", i, w_out, exp_out(0));
      end
      vectors++;
      if (w_req !== 17'h0) begin
        miscompares++;
        $display("FAIL mid_reset_req cyc=%0d got %h exp 0", i, w_req);
      end
    end
    for (int i = 0; i < FRAME + 60; i++) begin
      drive(($urandom % 3) != 0, 1'b0);
      vectors++;
      if (w_out !== exp_out(model_n)) begin
        miscompares++;
        $display("FAIL post_reset_out n=%0d got %h exp %h", model_n, w_out, exp_out(model_n));
      end
      vectors++;
      if (w_req !== exp_req(model_n, 1'b0)) begin
        miscompares++;
        $display("FAIL post_reset_req n=%0d got %h exp %h", model_n, w_req, exp_req(model_n, 1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_pix_en_random();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
